mult_div_unit: RTL and testbench

- Parametrised multiply/divide unit with architectural HI/LO registers.
- Sits in the E stage of the pipelined MIPS core and consumes the decoder's Start, HIWrite, LOWrite, HIRead and LORead controls.
- Adds what the decoder alone cannot provide: multi-cycle latency, a Busy stall indication, configurable latencies, and an exception/interrupt flush (Req) that suppresses architectural side effects.

---
 rtl/mult_div_unit.sv | 122 ++++++++++++
 tb/tb_mult_div_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multiply/divide unit with architectural HI/LO registers for the E stage.
// Results are computed at launch and committed to HI/LO after a configurable busy window.
module mult_div_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HIWrite,
  input  logic             LOWrite,
  input  logic             HIRead,
  input  logic             LORead,
  input  logic             Req,
  output logic             Busy,
  output logic [WIDTH-1:0] Out
);

  // state | meaning
  // IDLE  | nothing in flight; mthi/mtlo and launches accepted unless Req
  // RUN   | operation in flight; counter runs down, commit on the 1->0 edge
  typedef enum logic {IDLE, RUN} state_t;

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] pend_hi, pend_lo;
  logic             pend_ok;

  logic                 is_mult, is_div, launch;
  logic [2*WIDTH-1:0]   a_ext, b_ext, prod;
  logic                 op_signed_div, a_neg, b_neg, div_zero;
  logic [WIDTH-1:0]     a_mag, b_mag, dividend, divisor, q_raw, r_raw, quot, rem;

  assign is_mult = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
  assign is_div  = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
  assign launch  = Start && (is_mult || is_div);

  // One 2W-bit multiplier serves both flavours; only the operand extension differs.
  assign a_ext = (MDOp == OP_MULT) ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
  assign b_ext = (MDOp == OP_MULT) ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
  assign prod  = a_ext * b_ext;

  // Signed divide runs on magnitudes; min/-1 falls out naturally as LO=min, HI=0.
  assign op_signed_div = (MDOp == OP_DIV);
  assign a_neg    = op_signed_div && A[WIDTH-1];
  assign b_neg    = op_signed_div && B[WIDTH-1];
  assign a_mag    = a_neg ? (~A + {{(WIDTH-1){1'b0}}, 1'b1}) : A;
  assign b_mag    = b_neg ? (~B + {{(WIDTH-1){1'b0}}, 1'b1}) : B;
  assign div_zero = (B == '0);
  assign dividend = a_mag;
  assign divisor  = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_raw    = dividend / divisor;
  assign r_raw    = dividend % divisor;
  assign quot     = (a_neg ^ b_neg) ? (~q_raw + {{(WIDTH-1){1'b0}}, 1'b1}) : q_raw;
  assign rem      = a_neg ? (~r_raw + {{(WIDTH-1){1'b0}}, 1'b1}) : r_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      Busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_ok <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!Req) begin
            if (HIWrite) hi <= A;
            if (LOWrite) lo <= A;
            if (launch) begin
              state   <= RUN;
              Busy    <= 1'b1;
              cnt     <= is_mult ? CW'(MULT_LAT) : CW'(DIV_LAT);
              pend_hi <= is_mult ? prod[2*WIDTH-1:WIDTH] : rem;
              pend_lo <= is_mult ? prod[WIDTH-1:0]       : quot;
              pend_ok <= is_mult || !div_zero;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= IDLE;
            Busy  <= 1'b0;
            if (pend_ok) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    Out = '0;
    if (HIRead)      Out = hi;
    else if (LORead) Out = lo;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed cases plus randomized traffic
// checked against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  localparam int W        = 32;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Start = 1'b0;
  logic [2:0]    MDOp = '0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          HIWrite = 1'b0;
  logic          LOWrite = 1'b0;
  logic          HIRead = 1'b0;
  logic          LORead = 1'b0;
  logic          Req = 1'b0;
  logic          Busy;
  logic [W-1:0]  Out;

  mult_div_unit #(.WIDTH(W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .HIRead(HIRead), .LORead(LORead),
    .Req(Req), .Busy(Busy), .Out(Out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         busy;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int      busy_q[$];
  int      checks = 0;
  int      errors = 0;

  // Architectural model state.
  logic [W-1:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  logic         m_pok = 1'b0;
  int           m_left = 0;

  task automatic model_compute(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               output logic ok, output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    ok = 1'b1;
    rh = '0;
    rl = '0;
    case (op)
      3'd1: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      3'd2: begin pu = ua * ub; rh = pu[63:32]; rl = pu[31:0]; end
      3'd3: begin
        if (b == 0) ok = 1'b0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rl = 32'h8000_0000; rh = '0; end
        else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
      end
      3'd4: begin
        if (b == 0) ok = 1'b0;
        else begin rl = a / b; rh = a % b; end
      end
      default: ok = 1'b0;
    endcase
  endtask

  task automatic cycle(input logic st, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic hw, input logic lw, input logic hr, input logic lr, input logic rq);
    rd_exp_t e;
    logic ok;
    logic [W-1:0] rh, rl;
    Start = st; MDOp = op; A = a; B = b;
    HIWrite = hw; LOWrite = lw; HIRead = hr; LORead = lr; Req = rq;
    if (hr || lr) begin
      e.out  = hr ? m_hi : m_lo;
      e.busy = (m_left != 0);
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pok) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (!rq) begin
      if (hw) m_hi = a;
      if (lw) m_lo = a;
      if (st && op >= 3'd1 && op <= 3'd4) begin
        model_compute(op, a, b, ok, rh, rl);
        m_pok  = ok;
        m_phi  = rh;
        m_plo  = rl;
        m_left = (op <= 3'd2) ? MULT_LAT : DIV_LAT;
        busy_q.push_back(m_left);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_idle();
    while (m_left != 0) cycle(0, 0, '0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic read_both();
    cycle(0, 0, '0, '0, 0, 0, 1, 0, 0);
    cycle(0, 0, '0, '0, 0, 0, 0, 1, 0);
  endtask

  task automatic op_and_read(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    cycle(1, op, a, b, 0, 0, 0, 0, 0);
    wait_idle();
    read_both();
  endtask

  task automatic do_reset();
    rd_exp_t e;
    reset = 1'b1;
    m_hi = '0; m_lo = '0; m_left = 0; m_pok = 1'b0;
    busy_q.delete();
    Start = 0; HIWrite = 0; LOWrite = 0; Req = 0; LORead = 0; HIRead = 1;
    e.out = '0; e.busy = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    HIRead = 0; LORead = 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    LORead = 0;
    reset = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom % 16);
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: reads are the DUT's presented output; Busy windows are measured and scored.
  int run = 0;
  always @(negedge clk) begin
    rd_exp_t e;
    int exp_len;
    if (reset) run = 0;
    else if (Busy) run++;
    else if (run > 0) begin
      checks++;
      if (busy_q.size() == 0) begin
        errors++;
        $display("FAIL busy_len: got unexpected busy window of %0d cycles, required none", run);
      end else begin
        exp_len = busy_q.pop_front();
        if (run != exp_len) begin
          errors++;
          $display("FAIL busy_len: got %0d cycles, required %0d", run, exp_len);
        end
      end
      run = 0;
    end
    if (HIRead || LORead) begin
      checks += 2;
      if (exp_q.size() == 0) begin
        errors += 2;
        $display("FAIL read_out: got %h with no expected entry, required none", Out);
      end else begin
        e = exp_q.pop_front();
        if (Out !== e.out) begin
          errors++;
          $display("FAIL read_out: got %h, required %h (HIRead=%0b LORead=%0b)", Out, e.out, HIRead, LORead);
        end
        if (Busy !== e.busy) begin
          errors++;
          $display("FAIL read_busy: got %0b, required %0b", Busy, e.busy);
        end
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    read_both();

    op_and_read(3'd1, 32'hFFFF_FFFE, 32'd3);
    op_and_read(3'd2, 32'hFFFF_FFFF, 32'd2);
    op_and_read(3'd3, 32'hFFFF_FFF9, 32'd2);
    op_and_read(3'd4, 32'd7, 32'd2);

    cycle(0, 0, 32'h11, '0, 1, 0, 0, 0, 0);
    cycle(0, 0, 32'h22, '0, 0, 1, 0, 0, 0);
    op_and_read(3'd4, 32'd9, 32'd0);
    op_and_read(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);

    // Req suppression of launch and mthi; reads check Busy stays low.
    cycle(1, 3'd1, 32'd6, 32'd7, 0, 0, 0, 0, 1);
    read_both();
    cycle(0, 0, 32'h5, '0, 1, 0, 0, 0, 1);
    read_both();

    // mthi and a second Start while busy are both ignored.
    cycle(1, 3'd2, 32'd100, 32'd3, 0, 0, 0, 0, 0);
    cycle(0, 0, 32'h5, '0, 1, 0, 1, 0, 0);
    cycle(1, 3'd4, 32'd50, 32'd5, 0, 0, 0, 1, 0);
    wait_idle();
    read_both();

    // Reserved opcodes.
    cycle(1, 3'd0, 32'd3, 32'd3, 0, 0, 0, 0, 0);
    cycle(1, 3'd6, 32'd3, 32'd3, 0, 0, 1, 0, 0);
    read_both();

    // Reset two cycles into a multiply; nothing may land afterwards.
    cycle(1, 3'd1, 32'd1234, 32'd5678, 0, 0, 0, 0, 0);
    idle(2);
    do_reset();
    idle(DIV_LAT + 2);
    read_both();

    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 3) == 0, 3'($urandom % 8), pick(), pick(),
            ($urandom % 6) == 0, ($urandom % 6) == 0,
            ($urandom % 2) == 0, ($urandom % 2) == 0, ($urandom % 7) == 0);
    end
    wait_idle();
    read_both();

    idle(DIV_LAT + 5);
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL read_drain: got %0d unconsumed reads, required 0", exp_q.size());
    end
    if (busy_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL busy_drain: got %0d unfinished busy windows, required 0", busy_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
